// File: rtl/nand_flash_target.sv
// Cycle-based NAND flash target: decodes reset/read/program sequences on the NFC pins,
// holds a small page array and reports busy on F_RB. Optional status read: NAND_TARGET_STATUS_READ_EN.
module nand_flash_target #(
    parameter int PAGE_BYTES  = 32,
    parameter int PAGES       = 16,
    parameter int ADDR_CYCLES = 4,
    parameter int T_R         = 20,
    parameter int T_PROG      = 40,
    parameter int T_RST       = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    inout  wire  [7:0] F_IO,
    input  logic       F_CLE,
    input  logic       F_ALE,
    input  logic       F_WEN,
    input  logic       F_REN,
    output logic       F_RB
);
    localparam int CB   = $clog2(PAGE_BYTES);
    localparam int PB   = $clog2(PAGES);
    localparam int AW   = $clog2(ADDR_CYCLES);
    localparam int TMAX = (T_R > T_PROG) ? ((T_R > T_RST) ? T_R : T_RST)
                                         : ((T_PROG > T_RST) ? T_PROG : T_RST);
    localparam int CW   = $clog2(TMAX + 1);

    localparam logic [7:0] CMD_READ    = 8'h00;
    localparam logic [7:0] CMD_PROG    = 8'h80;
    localparam logic [7:0] CMD_CONFIRM = 8'h10;
    localparam logic [7:0] CMD_RESET   = 8'hFF;

    typedef enum logic [2:0] {
        IDLE, RD_ADDR, BUSY_RD, RD_OUT, PG_ADDR, PG_DATA, BUSY_PG, BUSY_RST
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CB-1:0]   col_q, col_d;
    logic [PB-1:0]   page_q, page_d;
    logic [AW-1:0]   acnt_q, acnt_d;
    logic            wen_q, ren_q;
    logic            stat_q;
    logic [7:0]      mem_q  [PAGES*PAGE_BYTES];
    logic [7:0]      pbuf_q [PAGE_BYTES];

    logic            wen_edge, ren_edge, is_cmd, is_addr, is_data;
    logic            fill_buf, buf_we, mem_we;
    logic [CB-1:0]   pg_idx;
    logic            io_oe;
    logic [7:0]      io_dout;

    assign wen_edge = !wen_q && F_WEN;
    assign ren_edge = !ren_q && F_REN;
    assign is_cmd   = wen_edge && F_CLE && !F_ALE;
    assign is_addr  = wen_edge && F_ALE && !F_CLE;
    assign is_data  = wen_edge && !F_ALE && !F_CLE;

    // Copy runs in the last PAGE_BYTES busy cycles so an early reset leaves the array untouched.
    assign pg_idx = CB'(PAGE_BYTES - 1) - cnt_q[CB-1:0];

    assign F_RB    = !(state_q == BUSY_RD || state_q == BUSY_PG || state_q == BUSY_RST);
    assign io_oe   = !F_REN && (stat_q || state_q == RD_OUT);
    assign io_dout = stat_q ? {1'b1, F_RB, 6'b0} : mem_q[{page_q, col_q}];
    assign F_IO    = io_oe ? io_dout : 8'hzz;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        col_d    = col_q;
        page_d   = page_q;
        acnt_d   = acnt_q;
        fill_buf = 1'b0;
        buf_we   = 1'b0;
        mem_we   = 1'b0;
        case (state_q)
            IDLE, RD_OUT: begin
                if (state_q == RD_OUT && ren_edge && !stat_q) col_d = col_q + 1'b1;
                if (is_cmd && F_IO == CMD_READ) begin
                    state_d = RD_ADDR;
                    acnt_d  = '0;
                end else if (is_cmd && F_IO == CMD_PROG) begin
                    state_d  = PG_ADDR;
                    acnt_d   = '0;
                    fill_buf = 1'b1;
                end
            end
            RD_ADDR, PG_ADDR: begin
                if (is_addr) begin
                    if (acnt_q == '0) col_d = F_IO[CB-1:0];
                    if (acnt_q == AW'(1)) page_d = F_IO[PB-1:0];
                    acnt_d = acnt_q + 1'b1;
                    if (acnt_q == AW'(ADDR_CYCLES - 1)) begin
                        acnt_d = '0;
                        if (state_q == RD_ADDR) begin
                            state_d = BUSY_RD;
                            cnt_d   = CW'(T_R - 1);
                        end else begin
                            state_d = PG_DATA;
                        end
                    end
                end
            end
            PG_DATA: begin
                if (is_data) begin
                    buf_we = 1'b1;
                    col_d  = col_q + 1'b1;
                end else if (is_cmd && F_IO == CMD_CONFIRM) begin
                    state_d = BUSY_PG;
                    cnt_d   = CW'(T_PROG - 1);
                end else if (is_cmd && F_IO == CMD_READ) begin
                    state_d = RD_ADDR;
                    acnt_d  = '0;
                end
            end
            BUSY_RD: begin
                if (cnt_q == '0) state_d = RD_OUT;
                else cnt_d = cnt_q - 1'b1;
            end
            BUSY_PG: begin
                mem_we = (cnt_q < CW'(PAGE_BYTES));
                if (cnt_q == '0) state_d = IDLE;
                else cnt_d = cnt_q - 1'b1;
            end
            BUSY_RST: begin
                if (cnt_q == '0) state_d = IDLE;
                else cnt_d = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (is_cmd && F_IO == CMD_RESET) begin
            state_d  = BUSY_RST;
            cnt_d    = CW'(T_RST - 1);
            fill_buf = 1'b0;
            buf_we   = 1'b0;
            mem_we   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            col_q   <= '0;
            page_q  <= '0;
            acnt_q  <= '0;
            wen_q   <= 1'b1;
            ren_q   <= 1'b1;
            for (int i = 0; i < PAGES*PAGE_BYTES; i++) mem_q[i] <= 8'hFF;
            for (int i = 0; i < PAGE_BYTES; i++) pbuf_q[i] <= 8'hFF;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            page_q  <= page_d;
            acnt_q  <= acnt_d;
            wen_q   <= F_WEN;
            ren_q   <= F_REN;
            if (fill_buf) begin
                for (int i = 0; i < PAGE_BYTES; i++) pbuf_q[i] <= 8'hFF;
            end else if (buf_we) begin
                pbuf_q[col_q] <= F_IO;
            end
            if (mem_we) mem_q[{page_q, pg_idx}] <= pbuf_q[pg_idx];
        end
    end

`ifdef NAND_TARGET_STATUS_READ_EN
    // Flag clears on the next command that the state machine actually accepts.
    logic stat_d;
    always_comb begin
        stat_d = stat_q;
        if (is_cmd && F_IO == 8'h70) stat_d = 1'b1;
        else if (is_cmd && (F_IO == CMD_RESET || (F_RB && state_d != state_q))) stat_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stat_q <= 1'b0;
        else stat_q <= stat_d;
    end
`else
    assign stat_q = 1'b0;
`endif

endmodule

// File: tb/tb_nand_flash_target.sv
// Scoreboard bench for nand_flash_target: read pulses push expected bytes, a monitor pops and compares.
module tb_nand_flash_target;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cle = 1'b0, ale = 1'b0, wen = 1'b1, ren = 1'b1, host_oe = 1'b0;
    logic [7:0] host_io = 8'h00;
    wire  [7:0] F_IO;
    wire        rb;

    // Released bus reads back as 0x00 through the pulldowns.
    localparam logic [7:0] REL = 8'h00;
`ifdef NAND_TARGET_STATUS_READ_EN
    localparam logic [7:0] ST_BUSY = 8'h80;
    localparam logic [7:0] ST_RDY  = 8'hC0;
`else
    localparam logic [7:0] ST_BUSY = REL;
    localparam logic [7:0] ST_RDY  = REL;
`endif

    assign F_IO = host_oe ? host_io : 8'hzz;
    for (genvar g = 0; g < 8; g++) begin : g_pd
        pulldown (F_IO[g]);
    end

    always #5 clk = ~clk;

    nand_flash_target dut (
        .clk   (clk),
        .rst_n (rst_n),
        .F_IO  (F_IO),
        .F_CLE (cle),
        .F_ALE (ale),
        .F_WEN (wen),
        .F_REN (ren),
        .F_RB  (rb)
    );

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_q [$];
    event       rd_ev;

    task automatic chk(input string nm, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, want);
        end
    endtask

    initial begin : monitor
        logic [7:0] e;
        forever begin
            @(rd_ev);
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rd_unexpected got=%02h want=none", F_IO);
            end else begin
                e = exp_q.pop_front();
                if (F_IO !== e) begin
                    bad++;
                    $display("FAIL rd_byte got=%02h want=%02h", F_IO, e);
                end
            end
        end
    end

    task automatic wr(input logic c, input logic a, input logic [7:0] d);
        @(negedge clk);
        cle = c; ale = a; host_io = d; host_oe = 1'b1; wen = 1'b0;
        @(negedge clk);
        wen = 1'b1;
        @(negedge clk);
        cle = 1'b0; ale = 1'b0; host_oe = 1'b0;
    endtask

    task automatic cmd(input logic [7:0] d); wr(1'b1, 1'b0, d); endtask
    task automatic adr(input logic [7:0] d); wr(1'b0, 1'b1, d); endtask
    task automatic dat(input logic [7:0] d); wr(1'b0, 1'b0, d); endtask

    task automatic addr4(input logic [7:0] col, input logic [7:0] page);
        adr(col); adr(page); adr(8'h00); adr(8'h00);
    endtask

    task automatic rd(input logic [7:0] want);
        @(negedge clk);
        ren = 1'b0;
        exp_q.push_back(want);
        @(posedge clk);
        #2;
        ->rd_ev;
        @(negedge clk);
        ren = 1'b1;
    endtask

    task automatic wait_rdy(output int n);
        n = 0;
        while (rb == 1'b0 && n < 1000) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "simulation timeout");
    end

    initial begin : stim
        int n;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rb", int'(rb), 1);
        rd(REL);

        cmd(8'hFF);
        wait_rdy(n);
        chk("reset_busy", n, 5);
        rd(REL);

        cmd(8'h80); addr4(8'h00, 8'h03);
        for (int i = 0; i < 32; i++) dat(8'(i));
        cmd(8'h10);
        wait_rdy(n);
        chk("prog_busy", n, 40);

        cmd(8'h00); addr4(8'h00, 8'h03);
        wait_rdy(n);
        chk("read_busy", n, 20);
        for (int i = 0; i < 32; i++) rd(8'(i));
        rd(8'h00);

        cmd(8'h00); addr4(8'h1E, 8'h05);
        wait_rdy(n);
        chk("read5_busy", n, 20);
        rd(8'hFF); rd(8'hFF); rd(8'hFF);

        cmd(8'h80); addr4(8'h00, 8'h02);
        for (int i = 0; i < 32; i++) dat(8'(8'h40 + i));
        cmd(8'h10);
        repeat (4) @(negedge clk);
        cmd(8'hFF);
        wait_rdy(n);
        chk("abort_busy", n, 5);
        cmd(8'h00); addr4(8'h00, 8'h02);
        wait_rdy(n);
        for (int i = 0; i < 32; i++) rd(8'hFF);
        cmd(8'h00); addr4(8'h05, 8'h03);
        wait_rdy(n);
        rd(8'h05);

        cmd(8'h00); addr4(8'h04, 8'h03);
        cmd(8'h80);
        dat(8'hAA);
        rd(REL);
        chk("busy_rb", int'(rb), 0);
        wait_rdy(n);
        rd(8'h04); rd(8'h05);

        cmd(8'h80); addr4(8'h00, 8'h07);
        dat(8'h5A); dat(8'hA5);
        cmd(8'h10);
        cmd(8'h70);
        rd(ST_BUSY);
        wait_rdy(n);
        rd(ST_RDY);
        cmd(8'h00); addr4(8'h00, 8'h07);
        wait_rdy(n);
        chk("read7_busy", n, 20);
        rd(8'h5A); rd(8'hA5); rd(8'hFF);

        repeat (3) @(negedge clk);
        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
